// File: rtl/teclado_hex_escaner_pkg.sv
// Shared definitions for the 4x4 hex keypad scanner: debounce FSM states,
// the per-frame scan result (key code plus a "key seen" flag, where a clear
// flag means no key), and the row/column to hex-code keymap.
package teclado_hex_escaner_pkg;

    typedef enum logic [1:0] {
        INACTIVO    = 2'd0,
        CONFIRMANDO = 2'd1,
        PRESIONADA  = 2'd2,
        SOLTANDO    = 2'd3
    } estado_t;

    // A scan result with valida=0 is the "no key" result.
    typedef struct packed {
        logic       valida;
        logic [3:0] codigo;
    } resultado_t;

    localparam resultado_t RESULTADO_NINGUNA = '{valida: 1'b0, codigo: 4'h0};
    localparam logic [3:0] COLUMNAS_RESET    = 4'b1110;

    // Keypad legend, row-major:
    //   r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: E 0 F D
    function automatic logic [3:0] codigo_tecla(input logic [1:0] fila, input logic [1:0] col);
        logic [3:0] c;
        c = 4'h0;
        case ({fila, col})
            4'b00_00: c = 4'h1;
            4'b00_01: c = 4'h2;
            4'b00_10: c = 4'h3;
            4'b00_11: c = 4'hA;
            4'b01_00: c = 4'h4;
            4'b01_01: c = 4'h5;
            4'b01_10: c = 4'h6;
            4'b01_11: c = 4'hB;
            4'b10_00: c = 4'h7;
            4'b10_01: c = 4'h8;
            4'b10_10: c = 4'h9;
            4'b10_11: c = 4'hC;
            4'b11_00: c = 4'hE;
            4'b11_01: c = 4'h0;
            4'b11_10: c = 4'hF;
            4'b11_11: c = 4'hD;
        endcase
        return c;
    endfunction

    // Result of one column sample: the lowest-index active-low row wins.
    function automatic resultado_t primera_fila(input logic [3:0] filas_n, input logic [1:0] col);
        resultado_t r;
        r = RESULTADO_NINGUNA;
        for (int i = 3; i >= 0; i--) begin
            if (!filas_n[i]) begin
                r.valida = 1'b1;
                r.codigo = codigo_tecla(2'(i), col);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/teclado_hex_escaner_sincronizador_2ff.sv
// Two-flop synchronizer for asynchronous inputs. Resets to all ones so that
// idle active-low keypad rows read as "no key" straight out of reset.
module sincronizador_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sinc_p0;
    logic [WIDTH-1:0] sinc_p1;

    // Two-stage metastability filter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sinc_p0 <= '1;
            sinc_p1 <= '1;
        end else begin
            sinc_p0 <= d;
            sinc_p1 <= sinc_p0;
        end
    end

    assign q = sinc_p1;

endmodule

// File: rtl/teclado_hex_escaner.sv
// 4x4 hex keypad scanner with frame-based debounce. Drives one column low at
// a time for SCAN_DIV cycles, samples the synchronized rows on the last cycle
// of each column, reduces each 4-column frame to one key (or none), and runs
// a debounce FSM once per frame. Emits a one-cycle TeclaValida pulse with the
// new code on Tecla for each accepted press; no roll-over.
// Optional build macro TECLADO_OPERANDOS_EN adds X/Y/SelY operand registers
// that are loaded alternately from accepted keys.
module teclado_hex_escaner
    import teclado_hex_escaner_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] Filas,
    output logic [3:0] Columnas,
    output logic [3:0] Tecla,
    output logic       TeclaValida,
    output logic       TeclaPresionada
`ifdef TECLADO_OPERANDOS_EN
    ,
    output logic [3:0] X,
    output logic [3:0] Y,
    output logic       SelY
`endif
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [DIV_W-1:0] DIV_FIN = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_FIN = CNT_W'(DEBOUNCE_FRAMES);
    localparam logic [CNT_W-1:0] CNT_UNO = CNT_W'(1);

    logic [3:0]       filas_sinc;
    logic [DIV_W-1:0] div_q;
    logic [1:0]       col_idx;
    logic [3:0]       columnas_q;
    logic             fin_columna;
    logic             fin_trama;
    resultado_t       muestra;
    resultado_t       trama_q;
    resultado_t       resultado;

    estado_t          estado, estado_sig;
    logic [3:0]       cand, cand_sig;
    logic [CNT_W-1:0] cnt, cnt_sig;
    logic             aceptar;
    logic [3:0]       tecla_q;
    logic             valida_q;
    logic             presionada;

    // ---- stage: row synchronization ----
    sincronizador_2ff #(.WIDTH(4)) u_sinc_filas (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (Filas),
        .q     (filas_sinc)
    );

    // ---- stage: column scan ----
    assign fin_columna = (div_q == DIV_FIN);
    assign fin_trama   = fin_columna && (col_idx == 2'd3);

    // Per-column divider and round-robin column drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q      <= '0;
            col_idx    <= 2'd0;
            columnas_q <= COLUMNAS_RESET;
        end else if (fin_columna) begin
            div_q      <= '0;
            col_idx    <= col_idx + 2'd1;
            columnas_q <= ~(4'b0001 << (col_idx + 2'd1));
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    // ---- stage: frame capture ----
    assign muestra   = primera_fila(filas_sinc, col_idx);
    // The first column with a hit owns the frame; the column-3 sample only
    // counts when nothing earlier in the frame was seen.
    assign resultado = trama_q.valida ? trama_q : muestra;

    // Hold the first hit of the current frame; clear at frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trama_q <= RESULTADO_NINGUNA;
        end else if (fin_trama) begin
            trama_q <= RESULTADO_NINGUNA;
        end else if (fin_columna && !trama_q.valida) begin
            trama_q <= muestra;
        end
    end

    // ---- stage: debounce FSM ----
    // State register plus registered key code and accept pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado   <= INACTIVO;
            cand     <= 4'h0;
            cnt      <= '0;
            tecla_q  <= 4'h0;
            valida_q <= 1'b0;
        end else begin
            estado   <= estado_sig;
            cand     <= cand_sig;
            cnt      <= cnt_sig;
            valida_q <= aceptar;
            if (aceptar) begin
                tecla_q <= cand_sig;
            end
        end
    end

    // Next-state logic, evaluated only on frame boundaries.
    always_comb begin
        estado_sig = estado;
        cand_sig   = cand;
        cnt_sig    = cnt;
        aceptar    = 1'b0;
        if (fin_trama) begin
            unique case (estado)
                INACTIVO: begin
                    if (resultado.valida) begin
                        cand_sig   = resultado.codigo;
                        cnt_sig    = CNT_UNO;
                        estado_sig = CONFIRMANDO;
                        if (cnt_sig == CNT_FIN) begin
                            aceptar    = 1'b1;
                            estado_sig = PRESIONADA;
                        end
                    end
                end
                CONFIRMANDO: begin
                    if (!resultado.valida) begin
                        estado_sig = INACTIVO;
                        cnt_sig    = '0;
                    end else begin
                        if (resultado.codigo == cand) begin
                            cnt_sig = cnt + 1'b1;
                        end else begin
                            cand_sig = resultado.codigo;
                            cnt_sig  = CNT_UNO;
                        end
                        if (cnt_sig == CNT_FIN) begin
                            aceptar    = 1'b1;
                            estado_sig = PRESIONADA;
                        end
                    end
                end
                PRESIONADA: begin
                    if (!resultado.valida) begin
                        cnt_sig    = CNT_UNO;
                        estado_sig = SOLTANDO;
                        if (cnt_sig == CNT_FIN) begin
                            cnt_sig    = '0;
                            estado_sig = INACTIVO;
                        end
                    end
                end
                SOLTANDO: begin
                    if (resultado.valida) begin
                        cnt_sig    = '0;
                        estado_sig = PRESIONADA;
                    end else begin
                        cnt_sig = cnt + 1'b1;
                        if (cnt_sig == CNT_FIN) begin
                            cnt_sig    = '0;
                            estado_sig = INACTIVO;
                        end
                    end
                end
            endcase
        end
    end

    // Held level: a key is considered down until the release is confirmed.
    always_comb begin
        presionada = 1'b0;
        if (estado == PRESIONADA || estado == SOLTANDO) begin
            presionada = 1'b1;
        end
    end

    assign Columnas        = columnas_q;
    assign Tecla           = tecla_q;
    assign TeclaValida     = valida_q;
    assign TeclaPresionada = presionada;

`ifdef TECLADO_OPERANDOS_EN
    logic [3:0] x_q;
    logic [3:0] y_q;
    logic       sel_y_q;

    // Alternate accepted keys between the X and Y operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= 4'h0;
            y_q     <= 4'h0;
            sel_y_q <= 1'b0;
        end else if (aceptar) begin
            if (!sel_y_q) begin
                x_q <= cand_sig;
            end else begin
                y_q <= cand_sig;
            end
            sel_y_q <= ~sel_y_q;
        end
    end

    assign X    = x_q;
    assign Y    = y_q;
    assign SelY = sel_y_q;
`endif

endmodule
